ioctl_multirom_loader: RTL and testbench

Parametrised successor to the single-slot BIND88 ROM download path in the PC8001M top level. It takes the hps_io ioctl byte stream and routes it to one of SLOTS ROM/RAM regions, chosen by ioctl_index. Bytes are packed into DATA_W-wide words with byte enables and written through a req/ack port that supports backpressure. It holds the core in reset while loading, and it reports per-slot loaded status and overflow.

---
 rtl/ioctl_multirom_loader.sv | 133 +++++++++++++
 tb/tb_ioctl_multirom_loader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioctl_multirom_loader.sv
// ioctl_multirom_loader: routes the hps_io ioctl byte stream into one of SLOTS memories as packed, byte-enabled words.
// The core is held in reset while a file loads. Backpressure is absorbed by a one-byte skid register.
module ioctl_multirom_loader #(
  parameter int SLOTS = 4,
  parameter int INDEX_BASE = 0,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int MAX_BYTES = 32768,
  localparam int BPW = DATA_W / 8,
  localparam int LB = $clog2(BPW),
  localparam int LW = LB > 0 ? LB : 1,
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic [SW-1:0]     mem_slot,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic [BPW-1:0]    mem_be,
  output logic              core_hold,
  output logic [SLOTS-1:0]  slot_loaded,
  output logic              overflow
);
  localparam logic [2:0] S_IDLE = 3'd0, S_COLLECT = 3'd1, S_WRITE = 3'd2, S_FLUSH = 3'd3, S_DONE = 3'd4;
  logic [2:0] state;
  logic dl_q, wrote, skid_v, src_v, in_range, mismatch, start;
  logic [24:0] skid_addr, src_addr;
  logic [7:0] skid_byte, src_byte;
  logic [ADDR_W-1:0] word;
  logic [LW-1:0] lane;
  logic [BPW-1:0] be_set;
  logic [DATA_W-1:0] data_set;
  // A parked skid byte always takes priority over a fresh strobe.
  always_comb begin
    src_v = skid_v | ioctl_wr;
    src_addr = skid_v ? skid_addr : ioctl_addr;
    src_byte = skid_v ? skid_byte : ioctl_dout;
    in_range = {7'd0, src_addr} < 32'(MAX_BYTES);
    word = ADDR_W'(src_addr >> LB);
    lane = LW'(src_addr % 25'(BPW));
    be_set = mem_be | BPW'(1 << lane);
    data_set = (mem_data & ~(DATA_W'(8'hff) << (8 * lane))) | (DATA_W'(src_byte) << (8 * lane));
    mismatch = (|mem_be) && (word != mem_addr);
    start = ioctl_download && !dl_q && state == S_IDLE &&
            {24'd0, ioctl_index} >= 32'(INDEX_BASE) && {24'd0, ioctl_index} < 32'(INDEX_BASE + SLOTS);
  end
  assign mem_req = state == S_WRITE || state == S_FLUSH;
  assign ioctl_wait = mem_req || skid_v;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      dl_q <= 1'b0;
      wrote <= 1'b0;
      skid_v <= 1'b0;
      skid_addr <= '0;
      skid_byte <= '0;
      mem_slot <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_be <= '0;
      core_hold <= 1'b0;
      slot_loaded <= '0;
      overflow <= 1'b0;
    end else begin
      dl_q <= ioctl_download;
      case (state)
        S_IDLE: if (start) begin
          state <= S_COLLECT;
          mem_slot <= SW'({24'd0, ioctl_index} - 32'(INDEX_BASE));
          overflow <= 1'b0;
          core_hold <= 1'b1;
          wrote <= 1'b0;
        end
        S_COLLECT: if (src_v && in_range && mismatch) begin
          state <= S_WRITE;
          if (!skid_v) begin
            skid_v <= 1'b1;
            skid_addr <= ioctl_addr;
            skid_byte <= ioctl_dout;
          end else if (ioctl_wr) overflow <= 1'b1;
        end else begin
          if (src_v && !in_range) overflow <= 1'b1;
          if (src_v && in_range) begin
            mem_addr <= word;
            mem_be <= be_set;
            mem_data <= data_set;
            if (&be_set) state <= S_WRITE;
          end
          if (skid_v) begin
            skid_v <= ioctl_wr;
            skid_addr <= ioctl_addr;
            skid_byte <= ioctl_dout;
          end
          if (!src_v && !ioctl_download) begin
            state <= |mem_be ? S_FLUSH : S_DONE;
            core_hold <= |mem_be;
          end
        end
        S_WRITE, S_FLUSH: begin
          if (ioctl_wr && skid_v) overflow <= 1'b1;
          if (ioctl_wr && !skid_v) begin
            skid_v <= 1'b1;
            skid_addr <= ioctl_addr;
            skid_byte <= ioctl_dout;
          end
          if (mem_ack) begin
            mem_be <= '0;
            mem_data <= '0;
            wrote <= 1'b1;
            // Skip COLLECT when nothing is left to gather so the hold drops right after the last ack.
            if (state == S_FLUSH || !(ioctl_download || skid_v || ioctl_wr)) begin
              state <= S_DONE;
              core_hold <= 1'b0;
            end else state <= S_COLLECT;
          end
        end
        S_DONE: begin
          if (wrote) slot_loaded[mem_slot] <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ioctl_multirom_loader.sv
// tb_ioctl_multirom_loader: a 16-bit/64-byte and an 8-bit/4-byte loader share one ioctl stream.
// Each is compared against a word-grouping model of the byte stream.
module tb_ioctl_multirom_loader;
  logic clk_sys = 0, reset = 1, dl = 0, wr = 0, ack16 = 1, ack8 = 1;
  logic [7:0] idx = 0, dout = 0;
  logic [24:0] addr = 0;
  logic wait16, req16, hold16, ovf16, wait8, req8, hold8, ovf8;
  logic [1:0] slot16, slot8;
  logic [14:0] addr16, addr8;
  logic [15:0] data16;
  logic [7:0] data8;
  logic [1:0] be16;
  logic [0:0] be8;
  logic [3:0] loaded16, loaded8;

  ioctl_multirom_loader #(.DATA_W(16), .MAX_BYTES(64)) dut16 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait16), .mem_req(req16), .mem_ack(ack16),
    .mem_slot(slot16), .mem_addr(addr16), .mem_data(data16), .mem_be(be16), .core_hold(hold16),
    .slot_loaded(loaded16), .overflow(ovf16));

  ioctl_multirom_loader #(.DATA_W(8), .MAX_BYTES(4)) dut8 (
    .clk_sys(clk_sys), .reset(reset), .ioctl_download(dl), .ioctl_index(idx), .ioctl_wr(wr),
    .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait8), .mem_req(req8), .mem_ack(ack8),
    .mem_slot(slot8), .mem_addr(addr8), .mem_data(data8), .mem_be(be8), .core_hold(hold8),
    .slot_loaded(loaded8), .overflow(ovf8));

  always #5 clk_sys = ~clk_sys;

  typedef struct {int slot; int addr; int data; int be;} wr_t;
  wr_t got[2][$];
  wr_t mq[$];
  int ba[$];
  int bd[$];
  int checks = 0, errors = 0, quiet_bad = 0;
  int bpw[2] = '{2, 1};
  int maxb[2] = '{64, 4};
  logic [3:0] sl_exp[2] = '{4'd0, 4'd0};
  logic ovf_exp[2] = '{1'b0, 1'b0};
  logic m_ovf, watch = 0;
  logic [47:0] snap;

  always @(negedge clk_sys) if (!reset) begin
    if (req16 && ack16) got[0].push_back('{int'(slot16), int'(addr16), int'(data16), int'(be16)});
    if (req8 && ack8) got[1].push_back('{int'(slot8), int'(addr8), int'(data8), int'(be8)});
    if (watch && (req16 | hold16 | wait16 | req8 | hold8 | wait8)) quiet_bad++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pk(wr_t w);
    logic [31:0] m = 0;
    for (int l = 0; l < 4; l++) if (w.be[l]) m[8*l +: 8] = 8'hff;
    return {8'(w.slot), 16'(w.addr), 32'(w.data) & m, 8'(w.be)};
  endfunction

  // Bytes collect into words; a word is emitted when full, when the next kept byte is in another word, or at the end.
  task automatic model(input int k);
    logic [31:0] d = 0;
    int be = 0, cw = 0, w, l;
    mq.delete();
    m_ovf = 0;
    for (int i = 0; i < ba.size(); i++) begin
      if (ba[i] >= maxb[k]) begin
        m_ovf = 1;
        continue;
      end
      w = ba[i] / bpw[k];
      l = ba[i] % bpw[k];
      if (be != 0 && w != cw) begin
        mq.push_back('{int'(idx), cw, int'(d), be});
        d = 0;
        be = 0;
      end
      cw = w;
      d[8*l +: 8] = 8'(bd[i]);
      be |= 1 << l;
      if (be == (1 << bpw[k]) - 1) begin
        mq.push_back('{int'(idx), cw, int'(d), be});
        d = 0;
        be = 0;
      end
    end
    if (be != 0) mq.push_back('{int'(idx), cw, int'(d), be});
  endtask

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic strobe(input int a, input int d);
    ba.push_back(a);
    bd.push_back(d & 255);
    addr = 25'(a);
    dout = 8'(d);
    wr = 1;
    tick();
    wr = 0;
  endtask

  task automatic settle;
    int n = 0;
    while ((wait16 | wait8) && n < 50) begin
      tick();
      n++;
    end
    chk("wait_bound", 64'(n >= 50), 0);
    tick();
  endtask

  task automatic send(input int a, input int d);
    strobe(a, d);
    settle();
  endtask

  task automatic start_dl(input int i);
    ba.delete();
    bd.delete();
    got[0].delete();
    got[1].delete();
    idx = 8'(i);
    dl = 1;
    tick();
    tick();
  endtask

  task automatic end_dl;
    int n = 0;
    logic [3:0] lk;
    dl = 0;
    while ((hold16 | hold8 | req16 | req8) && n < 100) begin
      tick();
      n++;
    end
    chk("hold_bound", 64'(n >= 100), 0);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      model(k);
      if (idx < 4) begin
        ovf_exp[k] = m_ovf;
        if (mq.size() > 0) sl_exp[k][idx[1:0]] = 1'b1;
      end else mq.delete();
      chk($sformatf("nwr%0d", k), 64'(got[k].size()), 64'(mq.size()));
      for (int j = 0; j < got[k].size() && j < mq.size(); j++)
        chk($sformatf("wr%0d_%0d", k, j), pk(got[k][j]), pk(mq[j]));
      lk = k == 0 ? loaded16 : loaded8;
      chk($sformatf("ovf%0d", k), 64'(k == 0 ? ovf16 : ovf8), 64'(ovf_exp[k]));
      chk($sformatf("loaded%0d", k), 64'(lk), 64'(sl_exp[k]));
    end
  endtask

  initial begin
    int a, n;
    repeat (3) tick();
    chk("rst16", {req16, hold16, wait16, ovf16, loaded16, be16, data16, addr16}, 0);
    chk("rst8", {req8, hold8, wait8, ovf8, loaded8, be8, data8, addr8}, 0);
    reset = 0;
    tick();
    // bytes 11..44, download dropping with the last strobe
    start_dl(0);
    send(0, 'h11);
    send(1, 'h22);
    send(2, 'h33);
    ba.push_back(3);
    bd.push_back('h44);
    addr = 3;
    dout = 8'h44;
    wr = 1;
    dl = 0;
    tick();
    wr = 0;
    chk("last_req", 64'(req16), 1);
    chk("hold_before_ack", 64'(hold16), 1);
    tick();
    chk("hold_after_ack", 64'(hold16), 0);
    end_dl();
    chk("t1_w0", pk(got[0][0]), {8'd0, 16'd0, 32'h2211, 8'd3});
    chk("t1_w1", pk(got[0][1]), {8'd0, 16'd1, 32'h4433, 8'd3});
    chk("t1_loaded", 64'(loaded16), 64'(4'b0001));
    // partial word flushed at the end
    start_dl(1);
    send(0, 'hAA);
    send(1, 'hBB);
    send(2, 'hCC);
    end_dl();
    chk("t2_flush", pk(got[0][1]), {8'd1, 16'd1, 32'hCC, 8'd1});
    chk("t2_ovf", 64'(ovf16), 0);
    // out-of-range index
    quiet_bad = 0;
    watch = 1;
    start_dl(4);
    send(0, 1);
    send(1, 2);
    send(2, 3);
    end_dl();
    watch = 0;
    chk("oor_quiet", 64'(quiet_bad), 0);
    // six bytes into the 4-byte slot of the 8-bit loader
    start_dl(2);
    for (int i = 0; i < 6; i++) send(i, $urandom);
    end_dl();
    chk("max_nwr", 64'(got[1].size()), 4);
    chk("max_ovf", 64'(ovf8), 1);
    chk("max_loaded", 64'(loaded8[2]), 1);
    // delayed ack with a byte parked in the skid
    start_dl(3);
    ack16 = 0;
    strobe(0, $urandom);
    strobe(1, $urandom);
    strobe(2, $urandom);
    snap = {1'b1, 1'b1, addr16, data16, be16, slot16, 11'd0};
    for (int i = 0; i < 10; i++) begin
      chk("ack_hold", 64'({req16, wait16, addr16, data16, be16, slot16, 11'd0}), 64'(snap));
      tick();
    end
    ack16 = 1;
    tick();
    settle();
    send(3, $urandom);
    end_dl();
    // randomized downloads, some out of range or past the byte limit
    repeat (6) begin
      n = $urandom_range(1, 16);
      a = $urandom_range(0, 70);
      start_dl($urandom_range(0, 5));
      for (int j = 0; j < n; j++) begin
        send(a, $urandom);
        a += ($urandom_range(0, 7) == 0) ? $urandom_range(2, 5) : 1;
      end
      end_dl();
    end
    // reset in the middle of a pending write
    start_dl(1);
    ack16 = 0;
    strobe(0, 5);
    strobe(1, 6);
    chk("pre_rst_req", 64'(req16), 1);
    #2 reset = 1;
    #1;
    chk("rst_async", {req16, hold16, wait16, loaded16, ovf16, req8, hold8, wait8, loaded8, ovf8}, 0);
    dl = 0;
    ack16 = 1;
    tick();
    tick();
    reset = 0;
    sl_exp = '{4'd0, 4'd0};
    ovf_exp = '{1'b0, 1'b0};
    tick();
    n = $urandom_range(2, 10);
    start_dl(2);
    for (int j = 0; j < n; j++) send(j, $urandom);
    end_dl();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
